// File: rtl/rv32_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pkg : RV32I opcodes, ALU op encoding and pipeline bus widths     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package rv32_pkg;

  localparam int IF_ID_W  = 64;
  localparam int ID_EXE_W = 149;
  localparam int WB_RF_W  = 38;
  localparam int ES_LD_W  = 7;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SR      = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  localparam logic [31:0] NOP_INST   = 32'h0000_0033;
  localparam logic [31:0] ECALL_INST = 32'h0000_0073;

  typedef enum logic [3:0] {
    ALU_ADD      = 4'd0,
    ALU_SUB      = 4'd1,
    ALU_SLL      = 4'd2,
    ALU_SLT      = 4'd3,
    ALU_SLTU     = 4'd4,
    ALU_XOR      = 4'd5,
    ALU_SRL      = 4'd6,
    ALU_SRA      = 4'd7,
    ALU_OR       = 4'd8,
    ALU_AND      = 4'd9,
    ALU_LUI_PASS = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rf_we;
    logic        mem_re;
    logic        mem_we;
    logic [2:0]  funct3;
    alu_op_e     alu_op;
    logic        src1_is_pc;
    logic        src2_is_imm;
    logic        is_br;
    logic        is_jal;
    logic        is_jalr;
    logic        is_ecall;
  } id_exe_bus_t;

  // alt selects SUB/SRA; callers qualify it (OP-IMM has no SUB form).
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     op = ALU_SLL;
      F3_SLT:     op = ALU_SLT;
      F3_SLTU:    op = ALU_SLTU;
      F3_XOR:     op = ALU_XOR;
      F3_SR:      op = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      op = ALU_OR;
      default:    op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_32x32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_32x32 : 2R/1W integer register file, x0 hardwired to zero,   |
// |                 same-cycle write-through bypass on both read ports   |
// | Revision      : 1.0                                                  |
// +----------------------------------------------------------------------+
module regfile_32x32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata
);

  logic [31:0] r_regs [32];
  logic        w_wr_en;

  assign w_wr_en = we && (waddr != 5'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (w_wr_en) begin
      r_regs[waddr] <= wdata;
    end
  end

  assign rdata1 = (raddr1 == 5'd0)                ? 32'd0 :
                  (w_wr_en && (waddr == raddr1))  ? wdata : r_regs[raddr1];
  assign rdata2 = (raddr2 == 5'd0)                ? 32'd0 :
                  (w_wr_en && (waddr == raddr2))  ? wdata : r_regs[raddr2];

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_stage : RV32I decode stage with register read and load-use stall  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module id_stage #(
  parameter int          ID_EXE_W = 149,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fs_to_ds_valid,
  input  logic [rv32_pkg::IF_ID_W-1:0] if_id_bus_in,
  output logic                         ds_allowin,
  input  logic                         es_allowin,
  output logic                         ds_to_es_valid,
  output logic [ID_EXE_W-1:0]          id_exe_bus_out,
  input  logic                         flush,
  input  logic [rv32_pkg::WB_RF_W-1:0] wb_rf_bus,
  input  logic [rv32_pkg::ES_LD_W-1:0] es_load_bus,
  output logic                         stall_flag,
  output logic                         ecall_flag
);
  import rv32_pkg::*;

  logic        r_ds_valid;
  logic [31:0] r_ds_inst;
  logic [31:0] r_ds_pc;

  logic        w_ready_go;
  logic        w_load_use;
  logic        w_uses_rs1;
  logic        w_uses_rs2;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic [4:0]  w_rd;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rs1_val, w_rs2_val;
  id_exe_bus_t w_bus;

  logic        w_es_valid, w_es_is_load;
  logic [4:0]  w_es_rd;

  assign {w_es_valid, w_es_is_load, w_es_rd} = es_load_bus;

  assign w_ready_go     = !w_load_use;
  assign ds_allowin     = !r_ds_valid || (w_ready_go && es_allowin);
  assign ds_to_es_valid = r_ds_valid && w_ready_go;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ds_valid <= 1'b0;
      r_ds_inst  <= NOP_INST;
      r_ds_pc    <= RESET_PC;
    end else if (flush) begin
      r_ds_valid <= 1'b0;
    end else if (ds_allowin) begin
      r_ds_valid <= fs_to_ds_valid;
      if (fs_to_ds_valid) begin
        {r_ds_inst, r_ds_pc} <= if_id_bus_in;
      end
    end
  end

  assign w_opcode = r_ds_inst[6:0];
  assign w_rd     = r_ds_inst[11:7];
  assign w_f3     = r_ds_inst[14:12];
  assign w_rs1    = r_ds_inst[19:15];
  assign w_rs2    = r_ds_inst[24:20];

  assign w_imm_i = {{20{r_ds_inst[31]}}, r_ds_inst[31:20]};
  assign w_imm_s = {{20{r_ds_inst[31]}}, r_ds_inst[31:25], r_ds_inst[11:7]};
  assign w_imm_b = {{19{r_ds_inst[31]}}, r_ds_inst[31], r_ds_inst[7],
                    r_ds_inst[30:25], r_ds_inst[11:8], 1'b0};
  assign w_imm_u = {r_ds_inst[31:12], 12'd0};
  assign w_imm_j = {{11{r_ds_inst[31]}}, r_ds_inst[31], r_ds_inst[19:12],
                    r_ds_inst[20], r_ds_inst[30:21], 1'b0};

  regfile_32x32 u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .raddr1 (w_rs1),
    .raddr2 (w_rs2),
    .rdata1 (w_rs1_val),
    .rdata2 (w_rs2_val),
    .we     (wb_rf_bus[37]),
    .waddr  (wb_rf_bus[36:32]),
    .wdata  (wb_rf_bus[31:0])
  );

  // Unrecognised encodings fall through with every control bit clear (a NOP).
  always_comb begin
    w_bus         = '0;
    w_bus.pc      = r_ds_pc;
    w_bus.rs1_val = w_rs1_val;
    w_bus.rs2_val = w_rs2_val;
    w_bus.funct3  = w_f3;
    w_uses_rs1    = 1'b1;
    w_uses_rs2    = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_uses_rs1        = 1'b0;
        w_bus.imm         = w_imm_u;
        w_bus.rd          = w_rd;
        w_bus.rf_we       = 1'b1;
        w_bus.src2_is_imm = 1'b1;
        w_bus.alu_op      = ALU_LUI_PASS;
      end
      OPC_AUIPC: begin
        w_uses_rs1        = 1'b0;
        w_bus.imm         = w_imm_u;
        w_bus.rd          = w_rd;
        w_bus.rf_we       = 1'b1;
        w_bus.src1_is_pc  = 1'b1;
        w_bus.src2_is_imm = 1'b1;
      end
      OPC_JAL: begin
        w_uses_rs1        = 1'b0;
        w_bus.imm         = w_imm_j;
        w_bus.rd          = w_rd;
        w_bus.rf_we       = 1'b1;
        w_bus.src1_is_pc  = 1'b1;
        w_bus.is_jal      = 1'b1;
      end
      OPC_JALR: begin
        w_bus.imm         = w_imm_i;
        w_bus.rd          = w_rd;
        w_bus.rf_we       = 1'b1;
        w_bus.src2_is_imm = 1'b1;
        w_bus.is_jalr     = 1'b1;
      end
      OPC_BRANCH: begin
        w_uses_rs2        = 1'b1;
        w_bus.imm         = w_imm_b;
        w_bus.alu_op      = ALU_SUB;
        w_bus.is_br       = 1'b1;
      end
      OPC_LOAD: begin
        w_bus.imm         = w_imm_i;
        w_bus.rd          = w_rd;
        w_bus.rf_we       = 1'b1;
        w_bus.mem_re      = 1'b1;
        w_bus.src2_is_imm = 1'b1;
      end
      OPC_STORE: begin
        w_uses_rs2        = 1'b1;
        w_bus.imm         = w_imm_s;
        w_bus.mem_we      = 1'b1;
        w_bus.src2_is_imm = 1'b1;
      end
      OPC_OP_IMM: begin
        w_bus.imm         = w_imm_i;
        w_bus.rd          = w_rd;
        w_bus.rf_we       = 1'b1;
        w_bus.src2_is_imm = 1'b1;
        w_bus.alu_op      = alu_from_f3(w_f3, (w_f3 == F3_SR) && r_ds_inst[30]);
      end
      OPC_OP: begin
        w_uses_rs2        = 1'b1;
        w_bus.rd          = w_rd;
        w_bus.rf_we       = 1'b1;
        w_bus.alu_op      = alu_from_f3(w_f3, r_ds_inst[30]);
      end
      OPC_SYSTEM: begin
        w_bus.is_ecall    = (r_ds_inst == ECALL_INST);
      end
      default: ;
    endcase
  end

  assign w_load_use = r_ds_valid && w_es_valid && w_es_is_load && (w_es_rd != 5'd0) &&
                      ((w_uses_rs1 && (w_rs1 == w_es_rd)) ||
                       (w_uses_rs2 && (w_rs2 == w_es_rd)));

  assign id_exe_bus_out = w_bus;
  assign stall_flag     = w_load_use;
  assign ecall_flag     = r_ds_valid && w_bus.is_ecall && w_ready_go && es_allowin && !flush;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_stage : directed self-checking bench for id_stage              |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module tb_id_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fs_to_ds_valid;
  logic [63:0]  if_id_bus_in;
  logic         ds_allowin;
  logic         es_allowin;
  logic         ds_to_es_valid;
  logic [148:0] id_exe_bus_out;
  logic         flush;
  logic [37:0]  wb_rf_bus;
  logic [6:0]   es_load_bus;
  logic         stall_flag;
  logic         ecall_flag;

  int checks   = 0;
  int failures = 0;

  id_stage #(.ID_EXE_W(149), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fs_to_ds_valid (fs_to_ds_valid),
    .if_id_bus_in   (if_id_bus_in),
    .ds_allowin     (ds_allowin),
    .es_allowin     (es_allowin),
    .ds_to_es_valid (ds_to_es_valid),
    .id_exe_bus_out (id_exe_bus_out),
    .flush          (flush),
    .wb_rf_bus      (wb_rf_bus),
    .es_load_bus    (es_load_bus),
    .stall_flag     (stall_flag),
    .ecall_flag     (ecall_flag)
  );

  always #5 clk = ~clk;

  // Bus fields sliced straight from the documented MSB-first layout.
  logic [31:0] f_pc, f_rs1, f_rs2, f_imm;
  logic [4:0]  f_rd;
  logic [3:0]  f_alu;
  logic f_rf_we, f_mem_re, f_mem_we, f_src2_imm, f_is_br, f_is_ecall;
  assign f_pc       = id_exe_bus_out[148:117];
  assign f_rs1      = id_exe_bus_out[116:85];
  assign f_rs2      = id_exe_bus_out[84:53];
  assign f_imm      = id_exe_bus_out[52:21];
  assign f_rd       = id_exe_bus_out[20:16];
  assign f_rf_we    = id_exe_bus_out[15];
  assign f_mem_re   = id_exe_bus_out[14];
  assign f_mem_we   = id_exe_bus_out[13];
  assign f_alu      = id_exe_bus_out[9:6];
  assign f_src2_imm = id_exe_bus_out[4];
  assign f_is_br    = id_exe_bus_out[3];
  assign f_is_ecall = id_exe_bus_out[0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic fetch(input logic [31:0] inst, input logic [31:0] pc);
    fs_to_ds_valid = 1'b1;
    if_id_bus_in   = {inst, pc};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; fs_to_ds_valid = 1'b0; if_id_bus_in = '0; es_allowin = 1'b1;
    flush = 1'b0; wb_rf_bus = '0; es_load_bus = '0;
    cyc(); cyc();
    rst_n = 1'b1;
    settle();
    chk("rst_allowin", ds_allowin, 1);
    chk("rst_to_es_valid", ds_to_es_valid, 0);
    chk("rst_stall", stall_flag, 0);
    chk("rst_ecall", ecall_flag, 0);

    // ADDI x1,x0,5 at pc 0
    fetch(32'h0050_0093, 32'h0);
    cyc(); fs_to_ds_valid = 1'b0; settle();
    chk("addi_valid", ds_to_es_valid, 1);
    chk("addi_imm", f_imm, 32'd5);
    chk("addi_rd", f_rd, 5'd1);
    chk("addi_rf_we", f_rf_we, 1);
    chk("addi_src2_imm", f_src2_imm, 1);
    chk("addi_alu", f_alu, 4'd0);
    chk("addi_pc", f_pc, 32'h0);

    // ADD x4,x3,x0 with writeback of x3 in the same cycle
    fetch(32'h0001_8233, 32'h4);
    cyc(); fs_to_ds_valid = 1'b0; es_allowin = 1'b0;
    wb_rf_bus = {1'b1, 5'd3, 32'hDEAD_BEEF}; settle();
    chk("bypass_rs1", f_rs1, 32'hDEAD_BEEF);
    chk("add_rs2_x0", f_rs2, 32'h0);
    chk("add_rd", f_rd, 5'd4);
    chk("add_allowin_blocked", ds_allowin, 0);
    cyc(); wb_rf_bus = '0; settle();
    chk("rf_stored_rs1", f_rs1, 32'hDEAD_BEEF);
    chk("held_pc", f_pc, 32'h4);

    // ADD x7,x0,x0 while writeback targets x0
    es_allowin = 1'b1;
    fetch(32'h0000_03B3, 32'h8);
    cyc(); fs_to_ds_valid = 1'b0; es_allowin = 1'b0;
    wb_rf_bus = {1'b1, 5'd0, 32'h1234_5678}; settle();
    chk("x0_no_bypass", f_rs1, 32'h0);
    cyc(); wb_rf_bus = '0; settle();
    chk("x0_after_write", f_rs1, 32'h0);

    // ADD x6,x5,x1 behind LW x5 in execute
    es_allowin = 1'b1;
    fetch(32'h0012_8333, 32'hC);
    cyc(); fetch(32'h0050_0093, 32'h10); es_load_bus = {1'b1, 1'b1, 5'd5}; settle();
    chk("lu_stall", stall_flag, 1);
    chk("lu_allowin", ds_allowin, 0);
    chk("lu_to_es_valid", ds_to_es_valid, 0);
    cyc(); settle();
    chk("lu_hold_pc", f_pc, 32'hC);
    chk("lu_stall_hold", stall_flag, 1);
    es_load_bus = {1'b1, 1'b1, 5'd1}; settle();
    chk("lu_rs2_stall", stall_flag, 1);
    es_load_bus = {1'b1, 1'b0, 5'd5}; settle();
    chk("lu_not_load", stall_flag, 0);
    es_load_bus = '0; settle();
    chk("lu_release_stall", stall_flag, 0);
    chk("lu_release_valid", ds_to_es_valid, 1);
    chk("lu_release_allowin", ds_allowin, 1);
    cyc(); fs_to_ds_valid = 1'b0; settle();
    chk("lu_issued_once", f_pc, 32'h10);
    es_load_bus = {1'b1, 1'b1, 5'd5}; settle();
    chk("addi_rs2_ignored", stall_flag, 0);
    es_load_bus = '0;

    // Flush coincident with a fetch offer
    flush = 1'b1; fetch(32'h0001_8233, 32'h14);
    cyc(); flush = 1'b0; fs_to_ds_valid = 1'b0; settle();
    chk("flush_to_es_valid", ds_to_es_valid, 0);
    chk("flush_allowin", ds_allowin, 1);
    cyc(); settle();
    chk("flush_still_empty", ds_to_es_valid, 0);

    // ECALL held by execute for three cycles
    fetch(32'h0000_0073, 32'h24);
    cyc(); fs_to_ds_valid = 1'b0; es_allowin = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("ecall_held_low", ecall_flag, 0);
      chk("ecall_decoded", f_is_ecall, 1);
      cyc();
    end
    es_allowin = 1'b1; settle();
    chk("ecall_pulse", ecall_flag, 1);
    cyc(); settle();
    chk("ecall_pulse_end", ecall_flag, 0);

    // BEQ x1,x2,-8
    fetch(32'hFE20_8CE3, 32'h28);
    cyc(); fs_to_ds_valid = 1'b0; es_allowin = 1'b0; settle();
    chk("beq_imm", f_imm, 32'hFFFF_FFF8);
    chk("beq_is_br", f_is_br, 1);
    chk("beq_rf_we", f_rf_we, 0);
    chk("beq_rd", f_rd, 5'd0);
    es_load_bus = {1'b1, 1'b1, 5'd2}; settle();
    chk("beq_rs2_stall", stall_flag, 1);
    es_load_bus = {1'b1, 1'b1, 5'd3}; settle();
    chk("beq_other_rd", stall_flag, 0);
    es_load_bus = '0; es_allowin = 1'b1;

    // SW x2,12(x1)
    fetch(32'h0020_A623, 32'h2C);
    cyc(); fs_to_ds_valid = 1'b0; es_allowin = 1'b0; settle();
    chk("sw_imm", f_imm, 32'd12);
    chk("sw_mem_we", f_mem_we, 1);
    chk("sw_rd", f_rd, 5'd0);
    chk("sw_rf_we", f_rf_we, 0);
    es_allowin = 1'b1;

    // LUI x2,0x12345 (rs1 field = 8 must not stall)
    fetch(32'h1234_5137, 32'h30);
    cyc(); fs_to_ds_valid = 1'b0; es_allowin = 1'b0; settle();
    chk("lui_imm", f_imm, 32'h1234_5000);
    chk("lui_alu", f_alu, 4'd10);
    chk("lui_rd", f_rd, 5'd2);
    es_load_bus = {1'b1, 1'b1, 5'd8}; settle();
    chk("lui_no_rs1", stall_flag, 0);
    es_load_bus = '0;

    // Reset in the middle of a held instruction
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1; settle();
    chk("rerst_allowin", ds_allowin, 1);
    chk("rerst_to_es_valid", ds_to_es_valid, 0);
    es_allowin = 1'b1;
    fetch(32'h0001_8233, 32'h34);
    cyc(); fs_to_ds_valid = 1'b0; settle();
    chk("rf_cleared", f_rs1, 32'h0);
    chk("rerst_mem_re", f_mem_re, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
